// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: fills the sample memory from a valid/ready stream, then holds start to the scanner until done
//   clk, rst_n          clock, asynchronous active-low reset
//   load                request a new fill (honoured only when idle)
//   in_valid/in_data    sample stream; in_ready high while filling
//   rd_addr/rd_data     asynchronous scanner read port
//   start/done          level start to scanner, scanner completion
//   busy, loaded_cnt    not idle, samples written in current/last fill
module mem_fill_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              start,
   input  logic              done,
   output logic              busy,
   output logic [ADDR_W:0]   loaded_cnt
);
   localparam int DEPTH = 2**ADDR_W;
   typedef enum logic [1:0] {IDLE, LOAD, RUN_ARM, RUN_WAIT} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_en;
   logic [DATA_W-1:0] mem [DEPTH];
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      wr_en    = state_q == LOAD && in_valid;
      case (state_q)
         IDLE: if (load) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            cnt_d    = '0;
         end
         LOAD: if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            state_d  = &wr_ptr_q ? RUN_ARM : LOAD;
         end
         // a done still high from the previous run must drop before completion counts
         RUN_ARM:  state_d = done ? RUN_ARM : RUN_WAIT;
         RUN_WAIT: state_d = done ? IDLE : RUN_WAIT;
         default:  state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr_q] <= in_data;
   assign rd_data    = mem[rd_addr];
   assign in_ready   = state_q == LOAD;
   assign start      = state_q == RUN_ARM || state_q == RUN_WAIT;
   assign busy       = state_q != IDLE;
   assign loaded_cnt = cnt_q;
endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb_mem_fill_ctrl: randomized and directed checks of mem_fill_ctrl against a flag-level reference model
module tb_mem_fill_ctrl;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        load = 1;
   logic        in_valid = 1;
   logic [7:0]  in_data = 0;
   logic        in_ready;
   logic [9:0]  rd_addr = 0;
   logic [7:0]  rd_data;
   logic        start;
   logic        done = 0;
   logic        busy;
   logic [10:0] loaded_cnt;

   mem_fill_ctrl dut (
      .clk(clk), .rst_n(rst_n), .load(load), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .start(start),
      .done(done), .busy(busy), .loaded_cnt(loaded_cnt)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   logic [7:0] m_mem [1024];
   bit   m_written [1024];
   bit   m_filling = 0, m_running = 0, m_done_low = 0;
   int   m_cnt = 0;
   int   ready_cycles = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_filling = 0;
      m_running = 0;
      m_cnt = 0;
   endtask

   task automatic compare_all();
      check("in_ready", in_ready, m_filling);
      check("start", start, m_running);
      check("busy", busy, m_filling | m_running);
      check("loaded_cnt", loaded_cnt, m_cnt);
      if (m_written[rd_addr]) check("rd_data", rd_data, m_mem[rd_addr]);
   endtask

   // One clock: apply the fill/run rules to the inputs present at the edge, then compare
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (m_filling) begin
         if (in_valid) begin
            m_mem[m_cnt % 1024] = in_data;
            m_written[m_cnt % 1024] = 1;
            m_cnt++;
            if (m_cnt == 1024) begin
               m_filling = 0;
               m_running = 1;
               m_done_low = 0;
            end
         end
      end else if (m_running) begin
         if (!m_done_low) m_done_low = !done;
         else if (done) m_running = 0;
      end else if (load) begin
         m_filling = 1;
         m_cnt = 0;
      end
      @(negedge clk);
      if (in_ready) ready_cycles++;
      compare_all();
   endtask

   // mode 0: back-to-back, data = index; 1: valid on alternate cycles; 2: random valid/data with a stray load at 300
   task automatic fill(input int mode, input int stop_at);
      int  k = 0;
      bit  poked = 0;
      ready_cycles = 0;
      load = 1;
      in_valid = 0;
      tick();
      load = 0;
      while (m_filling && m_cnt < stop_at) begin
         in_valid = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 0) : 1'($urandom);
         in_data  = mode == 2 ? 8'($urandom) : 8'(m_cnt);
         load     = mode == 2 && m_cnt == 300 && !poked;
         if (load) poked = 1;
         rd_addr  = 10'($urandom);
         tick();
         k++;
      end
      load = 0;
      in_valid = 0;
      if (mode == 0 && stop_at >= 1024) check("ready_cycles", ready_cycles, 1024);
   endtask

   task automatic read_check(input logic [9:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      check("rd_direct", rd_data, exp);
   endtask

   task automatic run_done();
      done = 0;
      repeat (3) tick();
      done = 1;
      tick();
      done = 0;
      check("start_after_done", start, 0);
      check("busy_after_done", busy, 0);
      tick();
   endtask

   initial begin
      logic [7:0] first;
      // T1: reset dominates load and in_valid
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_cnt", loaded_cnt, 0);
      rst_n = 1;
      load = 0;
      in_valid = 0;
      tick();
      // T2 + T4: back-to-back fill while a stale done is high
      done = 1;
      fill(0, 1024);
      check("cnt_full", loaded_cnt, 1024);
      check("start_full", start, 1);
      read_check(10'h3FF, 8'hFF);
      read_check(10'h005, 8'h05);
      repeat (5) tick();
      check("start_stale_done", start, 1);
      run_done();
      // T5: in_valid ignored in IDLE, stray load mid-fill ignored
      in_valid = 1;
      in_data = 8'hAA;
      rd_addr = 0;
      repeat (3) tick();
      check("idle_ready", in_ready, 0);
      check("idle_mem0", rd_data, 8'h00);
      fill(2, 301);
      check("cnt_300", loaded_cnt, 301);
      fill(2, 1024);
      check("cnt_after_stray", loaded_cnt, 1024);
      run_done();
      // Stray load resumes, not restarts: finish the second fill via the loop above
      // T3: alternate-cycle fill
      fill(1, 1024);
      check("alt_cnt", loaded_cnt, 1024);
      read_check(10'h3FF, 8'hFF);
      read_check(10'h080, 8'h80);
      run_done();
      // T6: async reset after 500 accepts, then refill
      fill(2, 500);
      check("cnt_500", loaded_cnt, 500);
      #2 rst_n = 0;
      #1;
      model_reset();
      check("arst_ready", in_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_cnt", loaded_cnt, 0);
      @(negedge clk);
      rst_n = 1;
      tick();
      fill(2, 1);
      first = m_mem[0];
      fill(2, 1024);
      read_check(10'h000, first);
      run_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
